// File: rtl/uart_receiver.sv
// uart_receiver: oversampling-free UART receiver for 8N1 / 8E1 frames.
// The serial line is synchronised, the start edge is qualified at half a
// bit period, and each following bit is sampled once per bit period at the
// centre of the bit. Baud control and parity enable are latched per frame.
module uart_receiver (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       Rxi,
    input  logic [2:0] BC,
    input  logic       PbitEna,
    output logic [7:0] RxData,
    output logic       RxValid,
    output logic       ParityErr,
    output logic       FrameErr,
    output logic       Busy
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    // Bit period in clock cycles for a given baud control code.
    function automatic logic [8:0] bit_period(input logic [2:0] bc);
        logic [8:0] period;
        case (bc)
            3'b001:  period = 9'd217;
            3'b010:  period = 9'd109;
            3'b011:  period = 9'd72;
            3'b100:  period = 9'd36;
            default: period = 9'd434;
        endcase
        return period;
    endfunction

    // Even parity of a data byte: the parity bit that makes the total even.
    function automatic logic even_parity(input logic [7:0] data);
        return ^data;
    endfunction

    // Synchroniser and its warm-up tracker.
    logic       sync1_q;
    logic       rxs_q;
    logic [1:0] sync_vld_q;

    // Frame state.
    state_t     state_q;
    logic [8:0] cnt_q;
    logic [2:0] bc_q;
    logic       pbit_q;
    logic       armed_q;
    logic [7:0] shift_q;
    logic [2:0] bit_idx_q;
    logic       par_err_q;

    // Registered outputs.
    logic [7:0] rx_data_q;
    logic       rx_valid_q;
    logic       parity_err_q;
    logic       frame_err_q;
    logic       busy_q;

    // Timing points derived from the latched baud control.
    logic [8:0] max_cntr_s;
    logic [8:0] half_s;
    logic [8:0] last_s;

    // Two-flop synchroniser; sync_vld_q masks the reset value of the flops
    // so that a line held low through reset cannot arm start detection.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q    <= 1'b1;
            rxs_q      <= 1'b1;
            sync_vld_q <= 2'b00;
        end else begin
            sync1_q    <= Rxi;
            rxs_q      <= sync1_q;
            sync_vld_q <= {sync_vld_q[0], 1'b1};
        end
    end

    // Decode the per-frame sampling points from the latched baud setting.
    always_comb begin
        max_cntr_s = bit_period(bc_q);
        half_s     = {1'b0, max_cntr_s[8:1]};
        last_s     = max_cntr_s - 9'd1;
    end

    // Receive FSM: start qualification, bit sampling and output pulses.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 9'd0;
            bc_q         <= 3'b000;
            pbit_q       <= 1'b0;
            armed_q      <= 1'b0;
            shift_q      <= 8'h00;
            bit_idx_q    <= 3'd0;
            par_err_q    <= 1'b0;
            rx_data_q    <= 8'h00;
            rx_valid_q   <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            // Pulses last exactly one cycle unless re-asserted below.
            rx_valid_q   <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            cnt_q        <= cnt_q + 9'd1;

            case (state_q)
                ST_IDLE: begin
                    cnt_q <= 9'd0;
                    if (armed_q && !rxs_q) begin
                        state_q <= ST_START;
                        bc_q    <= BC;
                        pbit_q  <= PbitEna;
                        armed_q <= 1'b0;
                        busy_q  <= 1'b1;
                    end else if (sync_vld_q[1] && rxs_q) begin
                        armed_q <= 1'b1;
                    end else begin
                        armed_q <= armed_q;
                    end
                end

                ST_START: begin
                    if (cnt_q == half_s) begin
                        cnt_q <= 9'd0;
                        if (!rxs_q) begin
                            state_q   <= ST_DATA;
                            bit_idx_q <= 3'd0;
                            par_err_q <= 1'b0;
                        end else begin
                            // Too short to be a start bit: drop it silently.
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        state_q <= ST_START;
                    end
                end

                ST_DATA: begin
                    if (cnt_q == last_s) begin
                        cnt_q     <= 9'd0;
                        shift_q   <= {rxs_q, shift_q[7:1]};
                        bit_idx_q <= bit_idx_q + 3'd1;
                        if (bit_idx_q == 3'd7) begin
                            state_q <= pbit_q ? ST_PARITY : ST_STOP;
                        end else begin
                            state_q <= ST_DATA;
                        end
                    end else begin
                        state_q <= ST_DATA;
                    end
                end

                ST_PARITY: begin
                    if (cnt_q == last_s) begin
                        cnt_q     <= 9'd0;
                        par_err_q <= (rxs_q != even_parity(shift_q));
                        state_q   <= ST_STOP;
                    end else begin
                        state_q <= ST_PARITY;
                    end
                end

                ST_STOP: begin
                    if (cnt_q == last_s) begin
                        cnt_q   <= 9'd0;
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                        if (rxs_q) begin
                            rx_data_q    <= shift_q;
                            rx_valid_q   <= 1'b1;
                            parity_err_q <= par_err_q;
                        end else begin
                            // Break or framing fault: wait for the line to
                            // go high again before accepting a new start.
                            frame_err_q <= 1'b1;
                            armed_q     <= 1'b0;
                        end
                    end else begin
                        state_q <= ST_STOP;
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                    cnt_q   <= 9'd0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign RxData    = rx_data_q;
    assign RxValid   = rx_valid_q;
    assign ParityErr = parity_err_q;
    assign FrameErr  = frame_err_q;
    assign Busy      = busy_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver: directed frames plus randomised
// frames, checked against an expectation queue built from the frame contents.
module tb_uart_receiver;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       Rxi = 1'b1;
    logic [2:0] BC = 3'b000;
    logic       PbitEna = 1'b0;
    logic [7:0] RxData;
    logic       RxValid;
    logic       ParityErr;
    logic       FrameErr;
    logic       Busy;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;

    typedef struct {
        bit         is_fe;
        logic [7:0] data;
        bit         perr;
        int         start_cyc;
        int         m;
        bit         pen;
        bit         b2b;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] model_data = 8'h00;
    int         last_valid_cyc = 0;

    uart_receiver dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .Rxi       (Rxi),
        .BC        (BC),
        .PbitEna   (PbitEna),
        .RxData    (RxData),
        .RxValid   (RxValid),
        .ParityErr (ParityErr),
        .FrameErr  (FrameErr),
        .Busy      (Busy)
    );

    // 50 MHz clock
    always #10 clk = ~clk;

    // free-running cycle count, used for latency measurements
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec = n_vec + 1;
        if (got !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int period_of(input logic [2:0] bc);
        int p;
        case (bc)
            3'b001:  p = 217;
            3'b010:  p = 109;
            3'b011:  p = 72;
            3'b100:  p = 36;
            default: p = 434;
        endcase
        return p;
    endfunction

    // Wait n rising edges, then settle 1 ns past the edge.
    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drive one frame bit-by-bit, each bit held for exactly one bit period.
    // BC/PbitEna are scrambled after the start bit to prove they are latched.
    task automatic send_frame(input logic [7:0] d, input logic [2:0] bc, input logic pen,
                              input logic pbit, input logic stopb, input bit expect_it,
                              input bit b2b);
        int   m;
        exp_t e;
        m       = period_of(bc);
        BC      = bc;
        PbitEna = pen;
        Rxi     = 1'b0;
        if (expect_it) begin
            e.is_fe     = (stopb == 1'b0);
            e.data      = d;
            e.perr      = pen && (pbit != (^d));
            e.start_cyc = cyc;
            e.m         = m;
            e.pen       = pen;
            e.b2b       = b2b;
            exp_q.push_back(e);
        end
        wait_cyc(m);
        BC      = ~bc;
        PbitEna = ~pen;
        for (int i = 0; i < 8; i++) begin
            Rxi = d[i];
            wait_cyc(m);
        end
        if (pen) begin
            Rxi = pbit;
            wait_cyc(m);
        end
        Rxi = stopb;
        wait_cyc(m);
    endtask

    // Output monitor: every RxValid/FrameErr pulse must match the next
    // expected frame; RxData must hold its last good value between pulses.
    always @(negedge clk) begin
        exp_t e;
        int   lat;
        int   base;
        if (!rst_n) begin
            model_data = 8'h00;
        end else if (RxValid || FrameErr) begin
            if (exp_q.size() == 0) begin
                check_value("unexpected_pulse", 32'({RxValid, FrameErr}), 32'd0);
            end else begin
                e    = exp_q.pop_front();
                // Rxi is driven just after an edge and seen at the next one
                lat  = cyc - e.start_cyc - 1;
                base = ((19 + 2 * int'(e.pen)) * e.m) / 2 + 2;
                check_value("frame_err_pulse", 32'(FrameErr), 32'(e.is_fe));
                check_value("rx_valid_pulse", 32'(RxValid), 32'(!e.is_fe));
                check_value("latency_window", 32'(lat >= base - 2 && lat <= base + 2), 32'd1);
                if (!e.is_fe) begin
                    model_data = e.data;
                    check_value("rx_data", 32'(RxData), 32'(e.data));
                    check_value("parity_err", 32'(ParityErr), 32'(e.perr));
                    if (e.b2b) begin
                        check_value("b2b_gap",
                                    32'((cyc - last_valid_cyc) >= 10 * e.m - 2 &&
                                        (cyc - last_valid_cyc) <= 10 * e.m + 2), 32'd1);
                    end
                    last_valid_cyc = cyc;
                end else begin
                    check_value("fe_no_parity", 32'(ParityErr), 32'd0);
                    check_value("fe_rxdata_hold", 32'(RxData), 32'(model_data));
                end
            end
        end else begin
            if (ParityErr) check_value("parity_without_valid", 32'(ParityErr), 32'd0);
            if (RxData !== model_data) check_value("rxdata_hold", 32'(RxData), 32'(model_data));
        end
    end

    initial begin
        logic [7:0] d;
        logic [2:0] bc;
        logic       pen;
        logic       pbit;
        logic       stopb;
        int         m;
        int         gap;

        // reset state
        wait_cyc(5);
        check_value("rst_rxdata", 32'(RxData), 32'h00);
        check_value("rst_rxvalid", 32'(RxValid), 32'd0);
        check_value("rst_parity", 32'(ParityErr), 32'd0);
        check_value("rst_frame", 32'(FrameErr), 32'd0);
        check_value("rst_busy", 32'(Busy), 32'd0);
        rst_n = 1'b1;
        wait_cyc(6);

        // 8N1 at the slowest rate
        send_frame(8'h0B, 3'b000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        wait_cyc(5);

        // 8E1, correct parity (0x6F has six ones), then wrong parity
        send_frame(8'h6F, 3'b011, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        wait_cyc(5);
        send_frame(8'h6F, 3'b011, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        wait_cyc(5);

        // stop bit low followed by a long break
        send_frame(8'hE8, 3'b001, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        wait_cyc(20 * 217);
        check_value("break_idle_busy", 32'(Busy), 32'd0);
        check_value("break_rxdata", 32'(RxData), 32'h6F);
        Rxi = 1'b1;
        wait_cyc(10);

        // short low glitch on an idle line
        BC  = 3'b100;
        Rxi = 1'b0;
        wait_cyc(10);
        Rxi = 1'b1;
        check_value("glitch_start_busy", 32'(Busy), 32'd1);
        wait_cyc(40);
        check_value("glitch_busy_clear", 32'(Busy), 32'd0);

        // back-to-back frames
        send_frame(8'h00, 3'b010, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        send_frame(8'hFF, 3'b010, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        wait_cyc(5);

        // reset pulse in the middle of data bit 4; upper nibble kept low so
        // the line stays low until the stop bit
        d  = 8'($urandom_range(0, 15));
        bc = 3'($urandom_range(1, 4));
        m  = period_of(bc);
        fork
            send_frame(d, bc, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
            begin
                wait_cyc(5 * m + m / 2);
                rst_n = 1'b0;
                wait_cyc(1);
                rst_n = 1'b1;
                @(negedge clk);
                check_value("midrst_rxdata", 32'(RxData), 32'h00);
                check_value("midrst_valid", 32'(RxValid), 32'd0);
                check_value("midrst_busy", 32'(Busy), 32'd0);
            end
        join
        wait_cyc(5);
        send_frame(8'hA5, bc, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        wait_cyc(5);

        // randomised frames, including bad parity and bad stop bits
        for (int k = 0; k < 10; k++) begin
            d     = 8'($urandom);
            bc    = 3'($urandom_range(0, 7));
            pen   = 1'($urandom_range(0, 1));
            pbit  = (^d) ^ ($urandom_range(0, 3) == 0);
            stopb = ($urandom_range(0, 7) != 0);
            send_frame(d, bc, pen, pbit, stopb, 1'b1, 1'b0);
            if (!stopb) begin
                Rxi = 1'b1;
                wait_cyc(4 + $urandom_range(0, 10));
            end else begin
                gap = $urandom_range(0, 20);
                if (gap > 0) wait_cyc(gap);
            end
        end

        wait_cyc(20);
        check_value("pending_expect", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/uart_receiver.md
UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001: clk  input  1  system clock, 50 MHz; all state changes on rising edge.
REQ-002: rst_n  input  1  synchronous, active-low reset, sampled on rising edge of clk.
REQ-003: Rxi  input  1  asynchronous UART serial line; idle high, 8N1 or 8E1 framing, LSB first.
REQ-004: BC  input  3  baud control; same encoding as the transmitter.
REQ-005: PbitEna  input  1  1 = frame carries an even-parity bit after the data bits; 0 = no parity bit.
REQ-006: RxData  output  8  last correctly framed received byte.
REQ-007: RxValid  output  1  one-cycle pulse when RxData is updated.
REQ-008: ParityErr  output  1  one-cycle pulse, coincident with RxValid, when the received parity mismatches.
REQ-009: FrameErr  output  1  one-cycle pulse when the stop bit samples low.
REQ-010: Busy  output  1  high in every state except IDLE.

Function
REQ-011: Rxi SHALL pass through a 2-flop synchronizer before use; rxs denotes the second-flop output, giving 2 cycles of latency.
REQ-012: Bit period Max_Cntr SHALL be 217 for BC=001, 109 for BC=010, 72 for BC=011, 36 for BC=100, and 434 for all other BC values.
REQ-013: BC and PbitEna SHALL be latched on start detection and held constant for the whole frame; changes mid-frame have no effect until the next frame.
REQ-014: Bit counter SHALL be 9 bits wide, clear on every state entry, and increment once per clk.
REQ-015: States: IDLE, START, DATA, PARITY, STOP; the state register is 3 bits wide.
REQ-016: IDLE -> START SHALL occur when armed=1 and rxs=0; armed SHALL be set whenever rxs=1 is observed in IDLE.
REQ-017: In START, when counter = Max_Cntr/2 (integer division: 217/108/54/36/18), go to DATA if rxs=0, else return to IDLE (glitch reject, no outputs).
REQ-018: DATA SHALL sample rxs when counter = Max_Cntr-1, shifting bits LSB first; after 8 samples go to PARITY if the latched PbitEna=1, else to STOP.
REQ-019: PARITY SHALL sample one bit at counter = Max_Cntr-1; ParityErr condition = (sampled bit != XOR of the 8 data bits).
REQ-020: STOP SHALL sample rxs at counter = Max_Cntr-1, then go to IDLE in the same cycle.
REQ-021: Stop sample = 1 -> RxData <= shifted byte, RxValid=1 for exactly one cycle, ParityErr=1 in that same cycle if a parity error was flagged.
REQ-022: Stop sample = 0 -> FrameErr=1 for one cycle, RxData unchanged, RxValid stays 0, armed cleared; no new frame starts until the line returns high (break handling).
REQ-023: Back-to-back frames: a start edge arriving half a bit after the stop sample SHALL be detected with no lost frame.
REQ-024: Latency: RxValid SHALL assert at (9.5 + PbitEna) * Max_Cntr + 2 +/- 2 cycles after the Rxi falling edge of the start bit.

Reset
REQ-025: While rst_n=0: state=IDLE, counter=0, shift register=0, RxData=8'h00, RxValid=0, ParityErr=0, FrameErr=0, Busy=0, armed=0, synchronizer flops=1.
REQ-026: Reset asserted mid-frame SHALL abort the frame with no output pulse; after release, a new frame is accepted only once rxs=1 has been seen.

Verification
REQ-027: BC=000, PbitEna=0, send 8'h0B at 434 cycles/bit -> RxData=8'h0B, a single RxValid pulse about 4125 cycles after the start edge, no error pulses.
REQ-028: BC=011, PbitEna=1, send 8'h6F with parity bit 0 -> RxData=8'h6F, RxValid=1, ParityErr=0; repeat with parity bit 1 -> RxValid=1 and ParityErr=1.
REQ-029: BC=001, send 8'hE8 with stop bit held 0, then the line held low for 20 bit times -> one FrameErr pulse, RxData unchanged, no further frames until the line goes high.
REQ-030: BC=100, 0-cycle low glitch of 10 cycles on an idle line -> START entered then abandoned, Busy returns to 0, no output pulses.
REQ-031: BC=010, two back-to-back frames 8'h00 then 8'hFF -> two RxValid pulses separated by 10 * 109 +/- 2 cycles, with RxData 8'h00 then 8'hFF.
REQ-032: rst_n pulsed low for 1 cycle during DATA bit 4 -> all outputs at reset values, no RxValid pulse, and the next clean frame is received correctly.
